// File: rtl/xgcd_axi_pkg.sv
// rtl/xgcd_axi_pkg.sv - AXI constants, transfer FSM states and burst helpers for the SRAM-to-AXI master
package xgcd_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

    localparam int unsigned AXI_4KB_BOUNDARY = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_FINISH
    } xfer_state_e;

    // Misaligned start, or a burst whose last byte lands past the 4KB page.
    function automatic logic burst_rejected(input logic [11:0] addr_lo, input logic [7:0] len);
        logic [13:0] end_byte;
        end_byte = {2'b00, addr_lo} + (({6'd0, len} + 14'd1) << 3);
        return (addr_lo[2:0] != 3'd0) || (end_byte > 14'(AXI_4KB_BOUNDARY));
    endfunction

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_to_axi_master_if.sv
// rtl/sram_to_axi_master_if.sv - AXI4 five-channel bundle with master/slave modports
interface sram_to_axi_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [63:0]           wdata;
    logic [7:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [63:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/sram_rd_skid.sv
// rtl/sram_rd_skid.sv - 2-entry buffer between 1-cycle-latency SRAM reads and the W channel
module sram_rd_skid #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fetch_en_i,
    output logic                  rd_req_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    input  logic                  out_en_i,
    output logic [DATA_WIDTH-1:0] tdata_o,
    output logic                  tvalid_o,
    input  logic                  tready_i
);

    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic                  inflight_q;
    logic [1:0]            count_q;
    logic                  pop;
    logic [2:0]            credit_used;

    assign tvalid_o = out_en_i && (count_q != 2'd0);
    assign tdata_o  = buf_q[rd_ptr_q];
    assign pop      = tvalid_o && tready_i;

    // A slot freed by this cycle's pop is reusable at once, giving 1 beat/cycle.
    assign credit_used = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_req_o    = fetch_en_i && (credit_used < 3'd2);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            inflight_q <= rd_req_o;
            count_q    <= credit_used[1:0];
            if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
            if (pop)        rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (inflight_q) buf_q[wr_ptr_q] <= sram_rdata_i;
    end

endmodule

// File: rtl/sram_to_axi_master.sv
// rtl/sram_to_axi_master.sv - AXI4 burst initiator moving 64-bit blocks between local SRAM and AXI
// Optional ID/RLAST checking built when SRAM_AXI_MASTER_CHECK_EN is defined.
module sram_to_axi_master
    import xgcd_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0,
    parameter int SRAM_AW    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_axi_addr_i,
    input  logic [SRAM_AW-1:0]    cmd_sram_addr_i,
    input  logic [7:0]            cmd_len_i,
    output logic                  done_o,
    output logic [2:0]            done_status_o,
    sram_to_axi_master_if.master  axi,
    output logic                  sram_cen_o,
    output logic                  sram_wen_o,
    output logic [SRAM_AW-1:0]    sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [7:0]            sram_wben_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    xfer_state_e           state_q;
    logic [ADDR_WIDTH-1:0] axi_addr_q;
    logic [SRAM_AW-1:0]    sram_base_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;
    logic [8:0]            fetch_cnt_q;
    logic [1:0]            resp_q;
    logic                  chk_err_q;
    logic                  done_q;
    logic [2:0]            status_q;
    logic                  awvalid_q;
    logic                  arvalid_q;
    logic                  bready_q;
    logic                  rready_q;

    logic                  w_hs;
    logic                  r_hs;
    logic                  last_beat;
    logic                  fetch_en;
    logic                  rd_req;
    logic [7:0]            sram_off;
    logic                  r_bad;
    logic                  b_bad;

    assign last_beat = (beat_q == len_q);
    assign w_hs      = axi.wvalid && axi.wready;
    assign r_hs      = axi.rvalid && rready_q;
    assign fetch_en  = ((state_q == ST_WR_ADDR) || (state_q == ST_WR_DATA))
                       && (fetch_cnt_q <= {1'b0, len_q});

`ifdef SRAM_AXI_MASTER_CHECK_EN
    assign r_bad = (axi.rid != ID_WIDTH'(AXI_ID)) || (axi.rlast != last_beat);
    assign b_bad = (axi.bid != ID_WIDTH'(AXI_ID));
`else
    logic unused_chk;
    assign unused_chk = ^{axi.rid, axi.bid, axi.rlast};
    assign r_bad      = 1'b0;
    assign b_bad      = 1'b0;
`endif

    sram_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fetch_en_i   (fetch_en),
        .rd_req_o     (rd_req),
        .sram_rdata_i (sram_rdata_i),
        .out_en_i     (state_q == ST_WR_DATA),
        .tdata_o      (axi.wdata),
        .tvalid_o     (axi.wvalid),
        .tready_i     (axi.wready)
    );

    // The SRAM port is shared: prefetch reads during writes, R-beat stores during reads.
    assign sram_off     = r_hs ? beat_q : fetch_cnt_q[7:0];
    assign sram_addr_o  = sram_base_q + SRAM_AW'(sram_off);
    assign sram_cen_o   = !(rd_req || r_hs);
    assign sram_wen_o   = !r_hs;
    assign sram_wdata_o = axi.rdata;
    assign sram_wben_o  = 8'h00;

    assign cmd_ready_o   = (state_q == ST_IDLE);
    assign done_o        = done_q;
    assign done_status_o = status_q;

    assign axi.awid    = ID_WIDTH'(AXI_ID);
    assign axi.awaddr  = axi_addr_q;
    assign axi.awlen   = len_q;
    assign axi.awsize  = AXI_SIZE_8B;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = awvalid_q;
    assign axi.wstrb   = 8'hFF;
    assign axi.wlast   = last_beat;
    assign axi.bready  = bready_q;
    assign axi.arid    = ID_WIDTH'(AXI_ID);
    assign axi.araddr  = axi_addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = AXI_SIZE_8B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            axi_addr_q  <= '0;
            sram_base_q <= '0;
            len_q       <= 8'd0;
            beat_q      <= 8'd0;
            fetch_cnt_q <= 9'd0;
            resp_q      <= AXI_RESP_OKAY;
            chk_err_q   <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= 3'd0;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (rd_req) fetch_cnt_q <= fetch_cnt_q + 9'd1;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        axi_addr_q  <= cmd_axi_addr_i;
                        sram_base_q <= cmd_sram_addr_i;
                        len_q       <= cmd_len_i;
                        beat_q      <= 8'd0;
                        fetch_cnt_q <= 9'd0;
                        resp_q      <= AXI_RESP_OKAY;
                        chk_err_q   <= 1'b0;
                        if (burst_rejected(cmd_axi_addr_i[11:0], cmd_len_i)) begin
                            state_q  <= ST_FINISH;
                            done_q   <= 1'b1;
                            status_q <= 3'b100;
                        end else if (cmd_write_i) begin
                            status_q  <= 3'd0;
                            awvalid_q <= 1'b1;
                            state_q   <= ST_WR_ADDR;
                        end else begin
                            status_q  <= 3'd0;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_ADDR: begin
                    if (axi.awready) begin
                        awvalid_q <= 1'b0;
                        state_q   <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (w_hs) begin
                        beat_q <= beat_q + 8'd1;
                        if (last_beat) begin
                            bready_q <= 1'b1;
                            state_q  <= ST_WR_RESP;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (axi.bvalid) begin
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        status_q <= {1'b0, b_bad ? AXI_RESP_SLVERR : axi.bresp};
                        state_q  <= ST_FINISH;
                    end
                end
                ST_RD_ADDR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (r_hs) begin
                        beat_q    <= beat_q + 8'd1;
                        resp_q    <= resp_max(resp_q, axi.rresp);
                        chk_err_q <= chk_err_q || r_bad;
                        if (last_beat) begin
                            rready_q <= 1'b0;
                            done_q   <= 1'b1;
                            status_q <= {1'b0, (chk_err_q || r_bad) ? AXI_RESP_SLVERR
                                                                    : resp_max(resp_q, axi.rresp)};
                            state_q  <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_to_axi_master.sv
// tb/tb_sram_to_axi_master.sv - directed self-checking bench for sram_to_axi_master
`timescale 1ns/1ps
module tb_sram_to_axi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_axi_addr = '0;
    logic [7:0]  cmd_sram_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        done;
    logic [2:0]  status;
    logic        sram_cen, sram_wen;
    logic [7:0]  sram_addr;
    logic [63:0] sram_wdata, sram_rdata;
    logic [7:0]  sram_wben;

    logic [63:0] mem [256];

    int checks = 0;
    int failures = 0;

    int cyc_s = 0, accept_cyc = 0, aw_cyc = 0, b_cyc = 0, done_cyc = 0;
    int aw_cnt = 0, ar_cnt = 0, awv_seen = 0, arv_seen = 0, done_cnt = 0;
    int w_total = 0, sr_total = 0, max_out = 0;
    int r_left = 0, r_beat = 0;
    logic b_pend = 1'b0;
    logic [31:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [2:0]  done_stat;
    logic [63:0] wq_data[$];
    logic        wq_last[$];
    int          wq_cyc[$];
    logic [7:0]  sw_addr[$];
    logic [63:0] sw_data[$];

    logic        w_rand = 1'b0, r_rand = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00;
    int          cfg_err_beat = 99;

    always #5 clk = ~clk;

    sram_to_axi_master_if #(.ADDR_WIDTH(32), .ID_WIDTH(4)) axi ();

    sram_to_axi_master dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_write_i     (cmd_write),
        .cmd_axi_addr_i  (cmd_axi_addr),
        .cmd_sram_addr_i (cmd_sram_addr),
        .cmd_len_i       (cmd_len),
        .done_o          (done),
        .done_status_o   (status),
        .axi             (axi),
        .sram_cen_o      (sram_cen),
        .sram_wen_o      (sram_wen),
        .sram_addr_o     (sram_addr),
        .sram_wdata_o    (sram_wdata),
        .sram_wben_o     (sram_wben),
        .sram_rdata_i    (sram_rdata)
    );

    always @(posedge clk) begin
        if (!sram_cen && sram_wen) sram_rdata <= mem[sram_addr];
    end

    // AXI slave responder, driven on the falling edge.
    always @(negedge clk) begin
        axi.awready = 1'b1;
        axi.arready = 1'b1;
        axi.bid     = 4'd0;
        axi.rid     = 4'd0;
        axi.wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        axi.bvalid  = b_pend;
        axi.bresp   = cfg_bresp;
        if (r_left > 0 && (!r_rand || $urandom_range(0, 1) == 1)) begin
            axi.rvalid = 1'b1;
            axi.rdata  = 64'(r_beat);
            axi.rresp  = (r_beat == cfg_err_beat) ? 2'b10 : 2'b00;
            axi.rlast  = (r_left == 1);
        end else begin
            axi.rvalid = 1'b0;
            axi.rdata  = '0;
            axi.rresp  = 2'b00;
            axi.rlast  = 1'b0;
        end
    end

    // Monitor: samples 1ns before each rising edge what that edge will register.
    always begin
        @(negedge clk);
        #4;
        cyc_s = cyc_s + 1;
        if (cmd_valid && cmd_ready) accept_cyc = cyc_s;
        if (axi.awvalid) awv_seen++;
        if (axi.arvalid) arv_seen++;
        if (axi.awvalid && axi.awready) begin
            aw_cnt++; aw_cyc = cyc_s;
            aw_addr = axi.awaddr; aw_len = axi.awlen; aw_size = axi.awsize; aw_burst = axi.awburst;
        end
        if (axi.arvalid && axi.arready) begin
            ar_cnt++; ar_addr = axi.araddr; ar_len = axi.arlen;
            r_left = int'(axi.arlen) + 1; r_beat = 0;
        end
        if (axi.wvalid && axi.wready) begin
            wq_data.push_back(axi.wdata); wq_last.push_back(axi.wlast); wq_cyc.push_back(cyc_s);
            w_total++;
            if (axi.wlast) b_pend = 1'b1;
        end
        if (axi.bvalid && axi.bready) begin b_pend = 1'b0; b_cyc = cyc_s; end
        if (axi.rvalid && axi.rready) begin r_beat++; r_left--; end
        if (!sram_cen && !sram_wen) begin sw_addr.push_back(sram_addr); sw_data.push_back(sram_wdata); end
        if (!sram_cen && sram_wen) sr_total++;
        if (sr_total - w_total > max_out) max_out = sr_total - w_total;
        if (done) begin done_cnt++; done_cyc = cyc_s; done_stat = status; end
    end

    task automatic clear_logs();
        wq_data.delete(); wq_last.delete(); wq_cyc.delete();
        sw_addr.delete(); sw_data.delete();
        max_out = 0;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [7:0] sa, input logic [7:0] len);
        @(negedge clk);
        cmd_write = wr; cmd_axi_addr = a; cmd_sram_addr = sa; cmd_len = len; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input string name);
        int n = 0;
        while (done_cnt == start && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == start) begin
            failures++;
            $display("FAIL %s_timeout: no DONE within 400 cycles", name);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (cmd_ready !== 1'b1)   begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (axi.awvalid !== 1'b0) begin failures++; $display("FAIL rst_awvalid got=%b exp=0", axi.awvalid); end
        checks++; if (axi.wvalid !== 1'b0)  begin failures++; $display("FAIL rst_wvalid got=%b exp=0", axi.wvalid); end
        checks++; if (axi.bready !== 1'b0)  begin failures++; $display("FAIL rst_bready got=%b exp=0", axi.bready); end
        checks++; if (axi.arvalid !== 1'b0) begin failures++; $display("FAIL rst_arvalid got=%b exp=0", axi.arvalid); end
        checks++; if (axi.rready !== 1'b0)  begin failures++; $display("FAIL rst_rready got=%b exp=0", axi.rready); end
        checks++; if (done !== 1'b0)        begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (status !== 3'b000)    begin failures++; $display("FAIL rst_status got=%b exp=000", status); end
        checks++; if (sram_cen !== 1'b1 || sram_wen !== 1'b1) begin
            failures++; $display("FAIL rst_sram_en got cen=%b wen=%b exp=1,1", sram_cen, sram_wen);
        end
    endtask

    task automatic test_write_single();
        int d0 = done_cnt, a0 = aw_cnt;
        clear_logs();
        mem[0] = 64'h0123456789ABCDEF;
        send_cmd(1'b1, 32'h0000_1000, 8'h00, 8'd0);
        wait_done(d0, "wr1");
        checks++; if (aw_cnt - a0 != 1) begin failures++; $display("FAIL wr1_aw_count got=%0d exp=1", aw_cnt - a0); end
        checks++; if (aw_addr !== 32'h1000 || aw_len !== 8'd0 || aw_size !== 3'd3 || aw_burst !== 2'b01) begin
            failures++; $display("FAIL wr1_aw_fields got addr=%h len=%0d size=%0d burst=%0d exp 1000/0/3/1", aw_addr, aw_len, aw_size, aw_burst);
        end
        checks++; if (aw_cyc != accept_cyc + 1) begin failures++; $display("FAIL wr1_aw_latency got=%0d exp=1", aw_cyc - accept_cyc); end
        checks++; if (wq_data.size() != 1) begin failures++; $display("FAIL wr1_w_count got=%0d exp=1", wq_data.size()); end
        else begin
            checks++; if (wq_data[0] !== 64'h0123456789ABCDEF || wq_last[0] !== 1'b1) begin
                failures++; $display("FAIL wr1_w_beat got data=%h last=%b exp=0123456789abcdef/1", wq_data[0], wq_last[0]);
            end
            checks++; if (wq_cyc[0] < accept_cyc + 2) begin failures++; $display("FAIL wr1_w_latency got=%0d exp>=2", wq_cyc[0] - accept_cyc); end
        end
        checks++; if (done_cnt - d0 != 1 || done_cyc != b_cyc + 1) begin
            failures++; $display("FAIL wr1_done got pulses=%0d delay=%0d exp 1/1", done_cnt - d0, done_cyc - b_cyc);
        end
        checks++; if (done_stat !== 3'b000) begin failures++; $display("FAIL wr1_status got=%b exp=000", done_stat); end
    endtask

    task automatic test_write_burst();
        int d0 = done_cnt;
        int nbad = 0;
        clear_logs();
        for (int i = 0; i < 16; i++) mem[8'h20 + i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        w_rand = 1'b1;
        send_cmd(1'b1, 32'h0000_3000, 8'h20, 8'd15);
        wait_done(d0, "wr16");
        w_rand = 1'b0;
        checks++; if (wq_data.size() != 16) begin failures++; $display("FAIL wr16_w_count got=%0d exp=16", wq_data.size()); end
        else begin
            for (int i = 0; i < 16; i++)
                if (wq_data[i] !== (64'hC0DE_0000_0000_0000 | 64'(i)) || wq_last[i] !== (i == 15)) nbad++;
            checks++; if (nbad != 0) begin failures++; $display("FAIL wr16_w_order got=%0d bad beats exp=0", nbad); end
        end
        checks++; if (max_out > 2) begin failures++; $display("FAIL wr16_inflight got=%0d exp<=2", max_out); end
        checks++; if (done_stat !== 3'b000) begin failures++; $display("FAIL wr16_status got=%b exp=000", done_stat); end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        clear_logs();
        for (int i = 0; i < 4; i++) mem[8'h40 + i] = 64'h1111_0000_0000_0000 + 64'(i);
        send_cmd(1'b1, 32'h0000_0100, 8'h40, 8'd3);
        wait_done(d0, "b2b");
        checks++; if (wq_cyc.size() != 4) begin failures++; $display("FAIL b2b_w_count got=%0d exp=4", wq_cyc.size()); end
        else begin
            checks++; if (wq_cyc[3] - wq_cyc[0] != 3) begin
                failures++; $display("FAIL b2b_throughput got span=%0d exp=3", wq_cyc[3] - wq_cyc[0]);
            end
        end
    endtask

    task automatic test_read_wrap();
        int d0 = done_cnt, r0 = ar_cnt;
        int nbad = 0;
        clear_logs();
        r_rand = 1'b1;
        send_cmd(1'b0, 32'h0000_2000, 8'hFC, 8'd7);
        wait_done(d0, "rd8");
        r_rand = 1'b0;
        checks++; if (ar_cnt - r0 != 1 || ar_addr !== 32'h2000 || ar_len !== 8'd7) begin
            failures++; $display("FAIL rd8_ar got cnt=%0d addr=%h len=%0d exp 1/2000/7", ar_cnt - r0, ar_addr, ar_len);
        end
        checks++; if (sw_addr.size() != 8) begin failures++; $display("FAIL rd8_sram_writes got=%0d exp=8", sw_addr.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                logic [7:0] ea;
                ea = 8'hFC + 8'(i);
                if (sw_addr[i] !== ea || sw_data[i] !== 64'(i)) nbad++;
            end
            checks++; if (nbad != 0) begin failures++; $display("FAIL rd8_sram_data got=%0d bad writes exp=0", nbad); end
        end
        checks++; if (done_stat !== 3'b000) begin failures++; $display("FAIL rd8_status got=%b exp=000", done_stat); end
    endtask

    task automatic test_reject();
        int d0 = done_cnt, awv0 = awv_seen, arv0 = arv_seen;
        send_cmd(1'b1, 32'h0000_0FF8, 8'h00, 8'd1);
        wait_done(d0, "rej4k");
        checks++; if (awv_seen != awv0) begin failures++; $display("FAIL rej4k_awvalid got=%0d cycles exp=0", awv_seen - awv0); end
        checks++; if (done_cyc != accept_cyc + 1 || done_stat !== 3'b100) begin
            failures++; $display("FAIL rej4k_done got delay=%0d status=%b exp 1/100", done_cyc - accept_cyc, done_stat);
        end
        d0 = done_cnt;
        send_cmd(1'b0, 32'h0000_1004, 8'h00, 8'd0);
        wait_done(d0, "rejmis");
        checks++; if (arv_seen != arv0) begin failures++; $display("FAIL rejmis_arvalid got=%0d cycles exp=0", arv_seen - arv0); end
        checks++; if (done_cyc != accept_cyc + 1 || done_stat !== 3'b100) begin
            failures++; $display("FAIL rejmis_done got delay=%0d status=%b exp 1/100", done_cyc - accept_cyc, done_stat);
        end
    endtask

    task automatic test_resp_errors();
        int d0 = done_cnt;
        cfg_err_beat = 2;
        send_cmd(1'b0, 32'h0000_4000, 8'h80, 8'd3);
        wait_done(d0, "slverr");
        cfg_err_beat = 99;
        checks++; if (done_stat !== 3'b010) begin failures++; $display("FAIL slverr_status got=%b exp=010", done_stat); end
        d0 = done_cnt;
        cfg_bresp = 2'b11;
        send_cmd(1'b1, 32'h0000_5000, 8'h00, 8'd0);
        wait_done(d0, "decerr");
        cfg_bresp = 2'b00;
        checks++; if (done_stat !== 3'b011) begin failures++; $display("FAIL decerr_status got=%b exp=011", done_stat); end
    endtask

    task automatic test_reset_mid_write();
        int d0 = done_cnt, w0 = w_total;
        int n = 0;
        for (int i = 0; i < 16; i++) mem[i] = 64'hBEEF_0000_0000_0000 + 64'(i);
        send_cmd(1'b1, 32'h0000_6000, 8'h00, 8'd15);
        while (w_total < w0 + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (w_total != w0 + 3) begin failures++; $display("FAIL midrst_beats got=%0d exp=3", w_total - w0); end
        checks++; if (axi.wvalid !== 1'b1) begin failures++; $display("FAIL midrst_wvalid_before got=%b exp=1", axi.wvalid); end
        rst = 1'b1;
        #1;
        checks++; if (axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0 || axi.bready !== 1'b0) begin
            failures++; $display("FAIL midrst_async got aw=%b w=%b b=%b exp 0/0/0", axi.awvalid, axi.wvalid, axi.bready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL midrst_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (done_cnt != d0) begin failures++; $display("FAIL midrst_done got=%0d pulses exp=0", done_cnt - d0); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_write_single();
        test_write_burst();
        test_back_to_back();
        test_read_wrap();
        test_reject();
        test_resp_errors();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
